// File: rtl/px_stream_framer.sv
// ============================================================================
// px_stream_framer : tags a valid-qualified pixel stream with position,
//                    line/frame flags, frame count and stall-abort detection.
// Revision 1.0
// ============================================================================
`default_nettype none

module px_stream_framer #(
   parameter int PX_SIZE        = 8,
   parameter int IMAGE_WIDTH    = 640,
   parameter int IMAGE_HEIGHT   = 480,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [PX_SIZE-1:0] input_data,
   input  logic               input_data_valid,
   output logic [PX_SIZE-1:0] output_data,
   output logic               output_data_valid,
   output logic [11:0]        px_col,
   output logic [11:0]        px_line,
   output logic               sol,
   output logic               eol,
   output logic               sof,
   output logic               eof,
   output logic [15:0]        frame_count,
   output logic               err_timeout,
   output logic               err_sticky
);

   localparam int          IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [11:0] COL_LAST  = 12'(IMAGE_WIDTH - 1);
   localparam logic [11:0] LINE_LAST = 12'(IMAGE_HEIGHT - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t             state_q,       state_d;
   logic [11:0]        col_q,         col_d;
   logic [11:0]        line_q,        line_d;
   logic [IDLE_W-1:0]  idle_q,        idle_d;
   logic [PX_SIZE-1:0] data_q,        data_d;
   logic               valid_q,       valid_d;
   logic [11:0]        px_col_q,      px_col_d;
   logic [11:0]        px_line_q,     px_line_d;
   logic               sol_q,         sol_d;
   logic               eol_q,         eol_d;
   logic               sof_q,         sof_d;
   logic               eof_q,         eof_d;
   logic [15:0]        frame_count_q, frame_count_d;
   logic               err_timeout_q, err_timeout_d;
   logic               err_sticky_q,  err_sticky_d;

   logic w_first_col;
   logic w_last_col;
   logic w_first_line;
   logic w_last_line;

   assign w_first_col  = (col_q == 12'd0);
   assign w_last_col   = (col_q == COL_LAST);
   assign w_first_line = (line_q == 12'd0);
   assign w_last_line  = (line_q == LINE_LAST);

   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      line_d        = line_q;
      idle_d        = idle_q;
      data_d        = data_q;
      valid_d       = input_data_valid;
      px_col_d      = px_col_q;
      px_line_d     = px_line_q;
      sol_d         = 1'b0;
      eol_d         = 1'b0;
      sof_d         = 1'b0;
      eof_d         = 1'b0;
      frame_count_d = frame_count_q;
      err_timeout_d = 1'b0;
      err_sticky_d  = err_sticky_q;

      if (input_data_valid) begin
         // Tags come from the position before this pixel advances the counters.
         data_d    = input_data;
         px_col_d  = col_q;
         px_line_d = line_q;
         sol_d     = w_first_col;
         eol_d     = w_last_col;
         sof_d     = w_first_col && w_first_line;
         eof_d     = w_last_col && w_last_line;
         idle_d    = '0;
         state_d   = ST_ACTIVE;
         if (w_last_col) begin
            col_d = 12'd0;
            if (w_last_line) begin
               line_d        = 12'd0;
               frame_count_d = frame_count_q + 16'd1;
               state_d       = ST_IDLE;
            end else begin
               line_d = line_q + 12'd1;
            end
         end else begin
            col_d = col_q + 12'd1;
         end
      end else if (state_q == ST_ACTIVE) begin
         // This idle cycle would bring the count to TIMEOUT_CYCLES: abort the frame.
         if (idle_q == IDLE_LAST) begin
            err_timeout_d = 1'b1;
            err_sticky_d  = 1'b1;
            col_d         = 12'd0;
            line_d        = 12'd0;
            idle_d        = '0;
            state_d       = ST_IDLE;
         end else begin
            idle_d = idle_q + IDLE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         col_q         <= 12'd0;
         line_q        <= 12'd0;
         idle_q        <= '0;
         data_q        <= '0;
         valid_q       <= 1'b0;
         px_col_q      <= 12'd0;
         px_line_q     <= 12'd0;
         sol_q         <= 1'b0;
         eol_q         <= 1'b0;
         sof_q         <= 1'b0;
         eof_q         <= 1'b0;
         frame_count_q <= 16'd0;
         err_timeout_q <= 1'b0;
         err_sticky_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         line_q        <= line_d;
         idle_q        <= idle_d;
         data_q        <= data_d;
         valid_q       <= valid_d;
         px_col_q      <= px_col_d;
         px_line_q     <= px_line_d;
         sol_q         <= sol_d;
         eol_q         <= eol_d;
         sof_q         <= sof_d;
         eof_q         <= eof_d;
         frame_count_q <= frame_count_d;
         err_timeout_q <= err_timeout_d;
         err_sticky_q  <= err_sticky_d;
      end
   end

   assign output_data       = data_q;
   assign output_data_valid = valid_q;
   assign px_col            = px_col_q;
   assign px_line           = px_line_q;
   assign sol               = sol_q;
   assign eol               = eol_q;
   assign sof               = sof_q;
   assign eof               = eof_q;
   assign frame_count       = frame_count_q;
   assign err_timeout       = err_timeout_q;
   assign err_sticky        = err_sticky_q;

endmodule

`default_nettype wire
